// File: rtl/fifo_dram_stream_reader_pkg.sv
// Shared helpers for the DRAM-backed stream FIFO: address/pointer width math and output reset value.
package fifo_dram_stream_reader_pkg;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Pointers carry one extra wrap bit above the storage address.
    function automatic int ptr_width(input int depth);
        return clogb2(depth) + 1;
    endfunction

    localparam logic out_rst_bit = 1'b0;

endpackage

// File: rtl/dram_simple_dual_port.sv
// Simple dual-port RAM: sync write on port A, async read on port B with optional output register.
// One cycle read latency with the register; dout_b holds whenever ren_b is low.
module dram_simple_dual_port
    import fifo_dram_stream_reader_pkg::*;
#(
    parameter int mem_width = 24,
    parameter int mem_depth = 32,
    parameter use_output_register = "true",
    parameter logic [mem_width-1:0] output_register_init_v = '0,
    parameter INIT_FILE = "no_init",
    parameter int simulation_delay = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wen_a,
    input  logic [clogb2(mem_depth)-1:0] addr_a,
    input  logic [mem_width-1:0]         din_a,
    input  logic                         ren_b,
    input  logic [clogb2(mem_depth)-1:0] addr_b,
    output logic [mem_width-1:0]         dout_b
);

    logic [mem_width-1:0] mem [mem_depth];

    // Simulation-only knobs with no synthesizable effect.
    logic cfg_unused;
    assign cfg_unused = (simulation_delay < 0) ^ (INIT_FILE == "no_init");

    always_ff @(posedge clk) begin
        if (wen_a) begin
            mem[addr_a] <= din_a;
        end
    end

    if (use_output_register == "true") begin : g_oreg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_b <= output_register_init_v;
            end else if (ren_b) begin
                dout_b <= mem[addr_b];
            end
        end
    end else begin : g_comb
        assign dout_b = mem[addr_b];
    end

endmodule

// File: rtl/fifo_dram_stream_reader.sv
// FIFO on a registered-output DRAM streaming as valid/ready master; write to m_axis_valid is 2 edges.
// Stalls hold the DRAM output register; writes while storage full drop (optional FIFO_ALMOST_FULL_EN).
module fifo_dram_stream_reader
    import fifo_dram_stream_reader_pkg::*;
#(
    parameter int fifo_width = 24,
    parameter int fifo_depth = 32,
    parameter int simulation_delay = 1
`ifdef FIFO_ALMOST_FULL_EN
    ,
    parameter int almost_full_th = fifo_depth - 2
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fifo_wen,
    input  logic [fifo_width-1:0]         fifo_din,
    output logic                          fifo_full,
    output logic                          fifo_full_n,
    output logic [fifo_width-1:0]         m_axis_data,
    output logic                          m_axis_valid,
    input  logic                          m_axis_ready,
    output logic [clogb2(fifo_depth)+1:0] data_cnt
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic                          fifo_almost_full
`endif
);

    localparam int pw = ptr_width(fifo_depth);
    localparam int aw = pw - 1;
    localparam int cw = clogb2(fifo_depth) + 2;

    logic [pw-1:0] wptr;
    logic [pw-1:0] rptr;
    logic [pw-1:0] store_cnt;
    logic          store_empty;
    logic          wen;
    logic          ren_b;

    assign store_cnt   = wptr - rptr;
    assign store_empty = (wptr == rptr);
    assign fifo_full   = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
    assign fifo_full_n = !fifo_full;
    assign wen         = fifo_wen && !fifo_full;
    // Refill the output stage only when it is empty or being consumed this cycle.
    assign ren_b       = !store_empty && (!m_axis_valid || m_axis_ready);
    assign data_cnt    = cw'(store_cnt) + cw'(m_axis_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            m_axis_valid <= 1'b0;
        end else begin
            if (wen) begin
                wptr <= wptr + 1'b1;
            end
            if (ren_b) begin
                rptr <= rptr + 1'b1;
            end
            if (ren_b) begin
                m_axis_valid <= 1'b1;
            end else if (m_axis_ready) begin
                m_axis_valid <= 1'b0;
            end
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    logic [pw-1:0] store_cnt_nxt;
    assign store_cnt_nxt = (wptr + pw'(wen)) - (rptr + pw'(ren_b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_almost_full <= 1'b0;
        end else begin
            fifo_almost_full <= (int'(store_cnt_nxt) >= almost_full_th);
        end
    end
`endif

    dram_simple_dual_port #(
        .mem_width              (fifo_width),
        .mem_depth              (fifo_depth),
        .use_output_register    ("true"),
        .output_register_init_v ({fifo_width{out_rst_bit}}),
        .INIT_FILE              ("no_init"),
        .simulation_delay       (simulation_delay)
    ) u_dram (
        .clk    (clk),
        .rst_n  (rst_n),
        .wen_a  (wen),
        .addr_a (wptr[aw-1:0]),
        .din_a  (fifo_din),
        .ren_b  (ren_b),
        .addr_b (rptr[aw-1:0]),
        .dout_b (m_axis_data)
    );

endmodule
